// File: rtl/border_painter_fx_if.sv
// border_painter_fx_if: pixel position, frame/hit pulses and registered border outputs of the border painter.
interface border_painter_fx_if;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       frame_start;
  logic       hit_left;
  logic       hit_right;
  logic       hit_top;
  logic       in_border;
  logic [5:0] color;
  logic [2:0] flashing;
  modport master (
    output hpos, vpos, frame_start, hit_left, hit_right, hit_top,
    input  in_border, color, flashing
  );
  modport slave (
    input  hpos, vpos, frame_start, hit_left, hit_right, hit_top,
    output in_border, color, flashing
  );
endinterface

// File: rtl/border_painter_fx.sv
// border_painter_fx: registered left/right/top border painter with per-side hit flash counters.
// Optional macro BORDER_BLINK_EN makes flashing sides alternate colours every frame.
module border_painter_fx #(
  parameter logic [5:0] BORDER_COLOR = 6'b111111,
  parameter logic [5:0] FLASH_COLOR  = 6'b000011,
  parameter logic [9:0] BORDER_LEFT  = 10'd0,
  parameter logic [9:0] BORDER_RIGHT = 10'd632,
  parameter logic [8:0] BORDER_TOP   = 9'd0,
  parameter int         BORDER_WIDTH = 3,
  parameter int         FLASH_FRAMES = 8,
  parameter int         CNT_W        = 4
) (
  input logic clk,
  input logic reset,
  border_painter_fx_if.slave bus
);
  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0] hit;
  logic [2:0] side;
  logic [CNT_W-1:0] sel_cnt;
  logic phase;
  assign hit = {bus.hit_top, bus.hit_right, bus.hit_left};
  assign side = {(bus.vpos >> BORDER_WIDTH) == (BORDER_TOP >> BORDER_WIDTH),
                 (bus.hpos >> BORDER_WIDTH) == (BORDER_RIGHT >> BORDER_WIDTH),
                 (bus.hpos >> BORDER_WIDTH) == (BORDER_LEFT >> BORDER_WIDTH)};
  // corners follow the top counter, then left over right
  assign sel_cnt = side[2] ? cnt[2] : side[0] ? cnt[0] : cnt[1];
  assign bus.flashing = {|cnt[2], |cnt[1], |cnt[0]};
`ifdef BORDER_BLINK_EN
  logic blink;
  always_ff @(posedge clk or posedge reset)
    if (reset) blink <= 1'b0;
    else blink <= blink ^ bus.frame_start;
  assign phase = blink;
`else
  assign phase = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else
      for (int i = 0; i < 3; i++)
        cnt[i] <= hit[i] ? CNT_W'(FLASH_FRAMES) :
                  (bus.frame_start && cnt[i] != '0) ? cnt[i] - 1'b1 : cnt[i];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.in_border <= 1'b0;
      bus.color     <= '0;
    end else begin
      bus.in_border <= |side;
      bus.color     <= !(|side) ? 6'b0 : (sel_cnt != '0 && phase) ? FLASH_COLOR : BORDER_COLOR;
    end
endmodule

// File: tb/tb_border_painter_fx.sv
// tb_border_painter_fx: directed sweeps plus randomized pixels/hits checked against a behavioural model.
module tb_border_painter_fx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  border_painter_fx_if bus();
  border_painter_fx dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_cmp = 0;
  int n_err = 0;
  int mcnt[3];
  bit mblink;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit in_side(int s, int h, int v);
    if (s == 0) return h / 8 == 0 / 8;
    if (s == 1) return h / 8 == 632 / 8;
    return v / 8 == 0 / 8;
  endfunction
  function automatic bit phase();
`ifdef BORDER_BLINK_EN
    return mblink;
`else
    return 1'b1;
`endif
  endfunction
  function automatic logic [2:0] exp_flash();
    return {mcnt[2] > 0, mcnt[1] > 0, mcnt[0] > 0};
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    mblink = 0;
  endtask
  task automatic step(input int h, input int v, input bit fs, input logic [2:0] hit);
    bit e_in;
    int s;
    logic [5:0] e_col;
    @(negedge clk);
    bus.hpos = 10'(h);
    bus.vpos = 9'(v);
    bus.frame_start = fs;
    {bus.hit_top, bus.hit_right, bus.hit_left} = hit;
    e_in = in_side(0, h, v) || in_side(1, h, v) || in_side(2, h, v);
    s = in_side(2, h, v) ? 2 : in_side(0, h, v) ? 0 : 1;
    e_col = !e_in ? 6'd0 : (mcnt[s] > 0 && phase()) ? 6'b000011 : 6'b111111;
    for (int k = 0; k < 3; k++)
      if (hit[k]) mcnt[k] = 8;
      else if (fs && mcnt[k] > 0) mcnt[k]--;
    if (fs) mblink = !mblink;
    @(posedge clk);
    #1;
    check("in_border", 32'(bus.in_border), 32'(e_in));
    check("color", 32'(bus.color), 32'(e_col));
    check("flashing", 32'(bus.flashing), 32'(exp_flash()));
  endtask
  initial begin
    bus.hpos = '0;
    bus.vpos = '0;
    bus.frame_start = 0;
    bus.hit_left = 0;
    bus.hit_right = 0;
    bus.hit_top = 0;
    model_reset();
    #1;
    check("rst_in_border", 32'(bus.in_border), 32'd0);
    check("rst_color", 32'(bus.color), 32'd0);
    check("rst_flashing", 32'(bus.flashing), 32'd0);
    @(negedge clk);
    reset = 0;
    for (int h = 0; h < 640; h++) step(h, 100, 0, 3'b000);
    for (int v = 0; v < 480; v++) step(300, v, 0, 3'b000);
    step(3, 3, 0, 3'b000);
    step(3, 100, 0, 3'b001);
    for (int f = 0; f < 8; f++) begin
      step(3, 100, 1, 3'b000);
      step(635, 100, 0, 3'b000);
      step(300, 4, 0, 3'b000);
    end
    step(3, 100, 0, 3'b000);
    step(300, 4, 0, 3'b100);
    for (int f = 0; f < 5; f++) step(300, 200, 1, 3'b000);
    step(3, 3, 1, 3'b100);
    step(3, 3, 0, 3'b000);
    step(3, 3, 1, 3'b000);
    step(3, 3, 0, 3'b000);
    step(636, 100, 0, 3'b010);
    for (int f = 0; f < 4; f++) begin
      step(636, 100, 1, 3'b000);
      step(636, 100, 0, 3'b000);
    end
    for (int n = 0; n < 3000; n++) begin
      int h, v;
      h = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 639) :
          ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(626, 639);
      v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 479);
      step(h, v, $urandom_range(0, 7) == 0,
           {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
    end
    step(3, 3, 0, 3'b111);
    step(200, 100, 0, 3'b000);
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    check("mid_rst_in_border", 32'(bus.in_border), 32'd0);
    check("mid_rst_color", 32'(bus.color), 32'd0);
    check("mid_rst_flashing", 32'(bus.flashing), 32'(exp_flash()));
    #2;
    reset = 0;
    step(2, 100, 0, 3'b000);
    check("post_rst_color", 32'(bus.color), 32'h3f);
    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 639), $urandom_range(0, 20), $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7) & $urandom_range(0, 7)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
